// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder definitions: prefix bytes, dropped codes, FSM encoding
// and the event word carried through the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status/ack bytes that never form part of a key sequence.
  localparam int PS2_N_DROP = 6;
  localparam logic [7:0] PS2_DROP_CODES [PS2_N_DROP] = '{
    8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic ps2_is_dropped(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_N_DROP; i++) begin
      if (b == PS2_DROP_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is reported as dropped.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  ps2_evt_t push_evt,
  input  logic     pop,
  output ps2_evt_t head,
  output logic     empty,
  output logic     full,
  output logic     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  ps2_evt_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_evt;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code sequence decoder with typematic filtering, held-key tracking,
// press counter and a buffered ready/valid event output.
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 received
// ST_BRK     | F0 received
// ST_EXT_BRK | E0 F0 received
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_release,
  output logic       held,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] press_count,
  output logic       overflow
);

  ps2_state_e state, state_nxt;
  logic       byte_ok;
  logic       is_key;
  logic       ev_valid;
  logic       ev_rel;
  logic       ev_ext;
  logic       key_match;
  logic       ev_push;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_drop;
  ps2_evt_t   ev_word;
  ps2_evt_t   head;

  assign byte_ok = in_valid & ~in_err & ~ps2_is_dropped(in_data);
  assign is_key  = byte_ok & (in_data != PS2_EXT) & (in_data != PS2_BRK);

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      if (!byte_ok) begin
        state_nxt = ST_IDLE;
      end else if (in_data == PS2_EXT) begin
        state_nxt = ST_EXT;
      end else if (in_data == PS2_BRK) begin
        state_nxt = (state == ST_IDLE || state == ST_EXT) ?
                    ((state == ST_EXT) ? ST_EXT_BRK : ST_BRK) : ST_BRK;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    ev_valid = 1'b0;
    ev_rel   = 1'b0;
    ev_ext   = 1'b0;
    if (is_key) begin
      ev_valid = 1'b1;
      ev_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
      ev_rel   = (state == ST_BRK) || (state == ST_EXT_BRK);
    end
  end

  // A make of the key already held is a typematic repeat and is swallowed.
  assign key_match = held && (held_ext == ev_ext) && (held_code == in_data);
  assign ev_push   = ev_valid && (ev_rel || !key_match);
  assign ev_word   = '{ext: ev_ext, rel: ev_rel, code: in_data};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      held        <= 1'b0;
      held_code   <= '0;
      held_ext    <= 1'b0;
      press_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (ev_valid && !ev_rel && !key_match) begin
        held        <= 1'b1;
        held_code   <= in_data;
        held_ext    <= ev_ext;
        press_count <= press_count + 8'd1;
      end
      if (ev_valid && ev_rel && key_match) held <= 1'b0;
      if (fifo_drop) overflow <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (ev_push),
    .push_evt (ev_word),
    .pop      (out_ready),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );

  assign out_valid   = ~fifo_empty;
  assign out_code    = head.code;
  assign out_ext     = head.ext;
  assign out_release = head.rel;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected events are queued as bytes
// are driven and compared as the consumer accepts them.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_release;
  logic       held;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] press_count;
  logic       overflow;

  int         errors = 0;
  int         checks = 0;
  logic [9:0] sb [$];
  logic [9:0] mon_exp;

  ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_err      (in_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_ext     (out_ext),
    .out_release (out_release),
    .held        (held),
    .held_code   (held_code),
    .held_ext    (held_ext),
    .press_count (press_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Accepted events are compared here, half a cycle before the accepting edge.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h expected=none", {out_ext, out_release, out_code});
      end else begin
        mon_exp = sb.pop_front();
        if ({out_ext, out_release, out_code} !== mon_exp) begin
          errors++;
          $display("FAIL event got=%h expected=%h", {out_ext, out_release, out_code}, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    in_valid = 1'b1;
    in_data  = b;
    in_err   = err;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic expect_evt(input logic ext, input logic rel, input logic [7:0] code);
    sb.push_back({ext, rel, code});
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #2;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d out_valid=%b expected 0/0", name, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h1C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn   = 1'b1;
    checks++;
    if ({out_valid, out_code, out_ext, out_release, held, held_code, held_ext,
         press_count, overflow} !== 29'd0) begin
      errors++;
      $display("FAIL reset_state valid=%b code=%h held=%b hcode=%h pc=%0d ovf=%b expected all 0",
               out_valid, out_code, held, held_code, press_count, overflow);
    end
  endtask

  task automatic test_make_break();
    reset_pulse();
    out_ready = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    checks++;
    if (held !== 1'b1 || held_code !== 8'h1C || press_count !== 8'd1) begin
      errors++;
      $display("FAIL make_held held=%b code=%h pc=%0d expected 1/1c/1", held, held_code, press_count);
    end
    send(8'hF0);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send(8'h1C);
    checks++;
    if (held !== 1'b0 || held_code !== 8'h1C || press_count !== 8'd1) begin
      errors++;
      $display("FAIL break_held held=%b code=%h pc=%0d expected 0/1c/1", held, held_code, press_count);
    end
    wait_drain("make_break");
  endtask

  task automatic test_typematic();
    reset_pulse();
    out_ready = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h1C);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    checks++;
    if (press_count !== 8'd1 || held !== 1'b0) begin
      errors++;
      $display("FAIL typematic pc=%0d held=%b expected 1/0", press_count, held);
    end
    wait_drain("typematic");
  endtask

  task automatic test_extended();
    reset_pulse();
    out_ready = 1'b1;
    expect_evt(1'b1, 1'b0, 8'h75);
    send(8'hE0); send(8'h75);
    checks++;
    if (held !== 1'b1 || held_ext !== 1'b1 || held_code !== 8'h75) begin
      errors++;
      $display("FAIL ext_held held=%b ext=%b code=%h expected 1/1/75", held, held_ext, held_code);
    end
    expect_evt(1'b1, 1'b1, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++;
    if (held !== 1'b0) begin
      errors++;
      $display("FAIL ext_break held=%b expected 0", held);
    end
    expect_evt(1'b0, 1'b0, 8'h75);
    send(8'h75);
    checks++;
    if (press_count !== 8'd2 || held_ext !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL plain_after_ext pc=%0d ext=%b held=%b expected 2/0/1", press_count, held_ext, held);
    end
    wait_drain("extended");
  endtask

  task automatic test_overflow();
    reset_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_evt(1'b0, 1'b0, 8'(8'h10 + i));
      send(8'(8'h10 + i));
    end
    checks++;
    if (overflow !== 1'b1 || press_count !== 8'd9 || held_code !== 8'h18) begin
      errors++;
      $display("FAIL overflow ovf=%b pc=%0d hcode=%h expected 1/9/18", overflow, press_count, held_code);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || {out_ext, out_release, out_code} !== 10'h010) begin
      errors++;
      $display("FAIL head_stable valid=%b head=%h expected 1/010", out_valid, {out_ext, out_release, out_code});
    end
    // Full FIFO with a pop in the same cycle must take the new event.
    out_ready = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h19);
    send(8'h19);
    checks++;
    if (press_count !== 8'd10 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop pc=%0d ovf=%b expected 10/1", press_count, overflow);
    end
    wait_drain("overflow");
  endtask

  task automatic test_reset_mid();
    reset_pulse();
    out_ready = 1'b1;
    send(8'hF0);
    reset_pulse();
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    checks++;
    if (press_count !== 8'd1 || held !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pc=%0d held=%b expected 1/1", press_count, held);
    end
    wait_drain("reset_mid");
  endtask

  task automatic test_err();
    reset_pulse();
    out_ready = 1'b1;
    send(8'hF0, 1'b1);
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    checks++;
    if (held !== 1'b1 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL err_byte held=%b pc=%0d expected 1/1", held, press_count);
    end
    wait_drain("err");
  endtask

  task automatic test_dropped();
    reset_pulse();
    out_ready = 1'b1;
    send(8'hAA); send(8'hFA); send(8'hFE);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || press_count !== 8'd0 || held !== 1'b0) begin
      errors++;
      $display("FAIL dropped valid=%b pc=%0d held=%b expected 0/0/0", out_valid, press_count, held);
    end
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'hE0); send(8'hAA); send(8'h1C);
    expect_evt(1'b1, 1'b0, 8'h75);
    send(8'hF0); send(8'hE0); send(8'h75);
    checks++;
    if (press_count !== 8'd2 || held_ext !== 1'b1) begin
      errors++;
      $display("FAIL resync pc=%0d ext=%b expected 2/1", press_count, held_ext);
    end
    wait_drain("dropped");
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_err    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_err();
    test_dropped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
